inst_prefetch_buf: RTL



---
 rtl/etcpu_pkg.sv | 26 ++
 rtl/fifo_sync.sv | 85 ++++++++
 rtl/inst_prefetch_buf.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/etcpu_pkg.sv
// etcpu_pkg
//   Shared types and constants for the etcpu instruction-fetch front end.
//   fetch_entry_t is one buffered instruction together with the PC it was
//   fetched from. align_pc/next_pc hold the PC arithmetic so every user
//   wraps and aligns the same way.
package etcpu_pkg;

  localparam int INST_W  = 32;
  localparam int PC_STEP = 4;

  typedef struct packed {
    logic [31:0]       pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  // Redirect targets may be misaligned; fetches are always word aligned.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & 32'hFFFF_FFFC;
  endfunction

  // Sequential fetch address. 32-bit modulo, so 0xFFFF_FFFC wraps to 0.
  function automatic logic [31:0] next_pc(input logic [31:0] pc);
    return pc + 32'(PC_STEP);
  endfunction

endpackage

// File: rtl/fifo_sync.sv
// fifo_sync
//   Single-clock FIFO with synchronous flush. The head entry is read
//   straight from the storage array, so a pushed entry is visible the
//   cycle after the push. Push and pop in the same cycle are accepted at
//   any occupancy, including full.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   i_push, i_data  write request and data
//   i_pop           remove the head entry (ignored when empty)
//   i_flush         discard all entries; wins over push and pop
//   o_data          head entry
//   o_full, o_empty occupancy flags
//   o_occ           number of stored entries
module fifo_sync #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_pop,
  input  logic                       i_flush,
  output logic [WIDTH-1:0]           o_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_occ
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_occ;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty = (r_occ == '0);
  assign o_full  = (r_occ == CW'(DEPTH));
  assign o_occ   = r_occ;
  assign o_data  = r_mem[r_rd_ptr];

  // A push into a full FIFO is only legal when the head leaves in the
  // same cycle, which frees the slot being written.
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // Pointers and occupancy. DEPTH is a power of two, so the pointers wrap
  // on their own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_occ    <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_occ <= r_occ + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

  // Storage is cleared on reset so the head reads as zero until the
  // first entry arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_do_push && !i_flush) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

endmodule

// File: rtl/inst_prefetch_buf.sv
// inst_prefetch_buf
//   Instruction prefetcher in front of the etcpu fetch stage. It issues
//   sequential word fetches over a req/gnt/rvalid port, buffers returned
//   instructions with their PCs, and hands them to fetch over valid/ready.
//   A redirect flushes the buffer, marks in-flight fetches for discard and
//   restarts fetching at the new PC.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   redir_vld, redir_pc           branch redirect pulse and target
//   mem_req, mem_addr             fetch request and word address
//   mem_gnt                       request accepted this cycle
//   mem_rvalid, mem_rdata         in-order read response
//   out_vld, out_pc, out_inst     instruction presented to fetch
//   out_rdy                       fetch consumes the head entry
module inst_prefetch_buf
  import etcpu_pkg::*;
#(
  parameter int          DEPTH     = 4,
  parameter int          MAX_OUTST = 2,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              redir_vld,
  input  logic [31:0]       redir_pc,
  output logic              mem_req,
  output logic [31:0]       mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [INST_W-1:0] mem_rdata,
  output logic              out_vld,
  output logic [31:0]       out_pc,
  output logic [INST_W-1:0] out_inst,
  input  logic              out_rdy
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = CW + 1;
  localparam int EW = $bits(fetch_entry_t);

  logic          r_started;
  logic [31:0]   r_fpc;
  logic [31:0]   r_rpc;
  logic [CW-1:0] r_outst;
  logic [CW-1:0] r_drop;

  logic [CW-1:0] w_occ;
  logic          w_full;
  logic          w_empty;
  logic [SW-1:0] w_credit_used;
  logic          w_issue;
  logic          w_drop_resp;
  logic          w_push;
  logic          w_pop;
  logic [31:0]   w_redir_target;
  fetch_entry_t  w_push_entry;
  fetch_entry_t  w_head;
  logic [EW-1:0] w_fifo_wdata;
  logic [EW-1:0] w_fifo_rdata;

  // A slot is reserved for every outstanding request, so a response can
  // always be pushed. r_started keeps mem_req low while reset is asserted
  // and drops it asynchronously when reset hits mid-stream.
  always_comb begin
    w_credit_used = SW'(w_occ) + SW'(r_outst);
    mem_req       = r_started && !redir_vld &&
                    (w_credit_used < SW'(DEPTH)) &&
                    (r_outst < CW'(MAX_OUTST));
  end

  assign mem_addr = r_fpc;
  assign w_issue  = mem_req && mem_gnt;

  // A response is dropped when it belongs to a fetch issued before a
  // redirect, including one that lands in the redirect cycle itself.
  assign w_drop_resp = mem_rvalid && (redir_vld || (r_drop != '0));
  assign w_push      = mem_rvalid && !w_drop_resp;

  assign w_redir_target = align_pc(redir_pc);

  assign w_push_entry.pc   = r_rpc;
  assign w_push_entry.inst = mem_rdata;
  assign w_fifo_wdata      = w_push_entry;
  assign w_head            = w_fifo_rdata;

  assign out_vld  = !w_empty;
  assign out_pc   = w_head.pc;
  assign out_inst = w_head.inst;
  assign w_pop    = out_vld && out_rdy;

  fifo_sync #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (w_fifo_wdata),
    .i_pop   (w_pop),
    .i_flush (redir_vld),
    .o_data  (w_fifo_rdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_occ   (w_occ)
  );

  // Issue enable: set one cycle after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_started <= 1'b0;
    end else begin
      r_started <= 1'b1;
    end
  end

  // Fetch PC advances on every accepted request; a redirect restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fpc <= RESET_PC;
    end else if (redir_vld) begin
      r_fpc <= w_redir_target;
    end else if (w_issue) begin
      r_fpc <= next_pc(r_fpc);
    end
  end

  // Response PC: the PC of the next response that will be kept. Responses
  // return in order, so it only advances on a push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rpc <= RESET_PC;
    end else if (redir_vld) begin
      r_rpc <= w_redir_target;
    end else if (w_push) begin
      r_rpc <= next_pc(r_rpc);
    end
  end

  // Outstanding count tracks requests granted but not yet answered. It
  // keeps counting through a redirect because those responses still come.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_outst <= '0;
    end else begin
      r_outst <= r_outst + CW'(w_issue) - CW'(mem_rvalid);
    end
  end

  // Drop count: how many of the in-flight responses are stale. On a
  // redirect every request still in flight after this cycle is stale;
  // no request is issued in a redirect cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop <= '0;
    end else if (redir_vld) begin
      r_drop <= r_outst - CW'(mem_rvalid);
    end else if (mem_rvalid && (r_drop != '0)) begin
      r_drop <= r_drop - CW'(1);
    end
  end

  a_no_push_full : assert property (@(posedge clk) disable iff (!rst_n)
    !(w_push && w_full && !w_pop));
  a_no_rvalid_idle : assert property (@(posedge clk) disable iff (!rst_n)
    !(mem_rvalid && (r_outst == '0)));
  a_drop_le_outst : assert property (@(posedge clk) disable iff (!rst_n)
    r_drop <= r_outst);
  a_addr_aligned : assert property (@(posedge clk) disable iff (!rst_n)
    mem_addr[1:0] == 2'b00);
  a_credit : assert property (@(posedge clk) disable iff (!rst_n)
    w_credit_used <= SW'(DEPTH));

endmodule
